// File: rtl/dac_error_counter.sv
// AGC drive-pulse error counter: captures PLUS/MINUS edges and accumulates them on FAZ1HI.
// Optional sticky overflow alarm enabled by defining DAC_ERRCNT_OVF_ALARM_EN.
module dac_error_counter #(
    parameter int LIMIT_FINE = 255,
    parameter int LIMIT_CA   = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FAZ1HI,
    input  logic       FAZ3HI,
    input  logic       EEC,
    input  logic       CA,
    input  logic       PLUS,
    input  logic       MINUS,
    output logic [8:0] ERRCNT,
    output logic       SAT,
    output logic       DRVACK,
    output logic       RUN,
    output logic       OVF
);

    // Handshake: DRVACK is a one-cycle valid strobe with no ready; ERRCNT is the
    // updated count in the same cycle and the consumer cannot stall the block.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              plus_q, minus_q;
    logic              plus_rise, minus_rise;
    logic              ppend, mpend, ppend_nxt, mpend_nxt;
    logic signed [8:0] cnt, cnt_nxt;
    logic              drvack_q, drvack_nxt;
    logic              sat_evt, lost_evt;
    logic              p_serv, m_serv;
    logic              clear_all, service;
    logic signed [9:0] cnt_w, lim_w, abs_w, base_w, sum_w;

    assign plus_rise  = PLUS & ~plus_q;
    assign minus_rise = MINUS & ~minus_q;

    // 10-bit signed view of the count so +/-1 around +/-255 never wraps
    assign cnt_w = {cnt[8], cnt};
    assign lim_w = CA ? 10'(LIMIT_CA) : 10'(LIMIT_FINE);
    assign abs_w = cnt_w[9] ? -cnt_w : cnt_w;

    assign clear_all = (state == S_IDLE) || !EEC;
    assign service   = (state == S_RUN) && FAZ1HI && !FAZ3HI;

    always_comb begin
        state_nxt  = state;
        ppend_nxt  = ppend;
        mpend_nxt  = mpend;
        cnt_nxt    = cnt;
        drvack_nxt = 1'b0;
        sat_evt    = 1'b0;
        lost_evt   = 1'b0;
        p_serv     = 1'b0;
        m_serv     = 1'b0;
        base_w     = cnt_w;
        sum_w      = cnt_w;

        case (state)
            S_IDLE:  if (EEC) state_nxt = S_ARM;
            S_ARM:   if (FAZ3HI) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
        if (!EEC) state_nxt = S_IDLE;

        if (clear_all) begin
            ppend_nxt = 1'b0;
            mpend_nxt = 1'b0;
            cnt_nxt   = '0;
        end else begin
            // Clamp first so a limit drop (CA rising) and a service compose cleanly
            if (cnt_w > lim_w)
                base_w = lim_w;
            else if (cnt_w < -lim_w)
                base_w = -lim_w;

            p_serv = service & ppend;
            m_serv = service & mpend;
            if (p_serv || m_serv) begin
                drvack_nxt = 1'b1;
                if (p_serv && !m_serv) begin
                    sum_w = base_w + 10'sd1;
                    if (sum_w > lim_w) sat_evt = 1'b1;
                    else               base_w  = sum_w;
                end else if (m_serv && !p_serv) begin
                    sum_w = base_w - 10'sd1;
                    if (sum_w < -lim_w) sat_evt = 1'b1;
                    else                base_w  = sum_w;
                end
            end
            if (p_serv) ppend_nxt = 1'b0;
            if (m_serv) mpend_nxt = 1'b0;

            // A fresh edge on its own service cycle re-arms the flag instead of being lost
            if (plus_rise) begin
                lost_evt  = lost_evt | (ppend & ~p_serv);
                ppend_nxt = 1'b1;
            end
            if (minus_rise) begin
                lost_evt  = lost_evt | (mpend & ~m_serv);
                mpend_nxt = 1'b1;
            end
            cnt_nxt = base_w[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            plus_q   <= 1'b0;
            minus_q  <= 1'b0;
            ppend    <= 1'b0;
            mpend    <= 1'b0;
            cnt      <= '0;
            drvack_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            plus_q   <= PLUS;
            minus_q  <= MINUS;
            ppend    <= ppend_nxt;
            mpend    <= mpend_nxt;
            cnt      <= cnt_nxt;
            drvack_q <= drvack_nxt;
        end
    end

    assign ERRCNT = cnt;
    assign DRVACK = drvack_q;
    assign RUN    = (state == S_RUN);
    assign SAT    = (abs_w == lim_w);

`ifdef DAC_ERRCNT_OVF_ALARM_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst || clear_all)
            ovf_q <= 1'b0;
        else if (sat_evt || lost_evt)
            ovf_q <= 1'b1;
    end

    assign OVF = ovf_q;
`else
    logic unused_alarm_evt;
    assign unused_alarm_evt = sat_evt | lost_evt;
    assign OVF = 1'b0;
`endif

endmodule
